// File: rtl/tone_pkg.sv
// Shared definitions for the tone voice bank: note codes, voice state encoding, pitch table.
package tone_pkg;

    // Note codes (0 is a rest)
    localparam int unsigned REST = 0;
    localparam int unsigned A4   = 1;
    localparam int unsigned B4   = 2;
    localparam int unsigned C4   = 3;
    localparam int unsigned D4   = 4;
    localparam int unsigned E4   = 5;
    localparam int unsigned F4   = 6;
    localparam int unsigned G4   = 7;
    localparam int unsigned BF4  = 8;
    localparam int unsigned C5   = 9;
    localparam int unsigned CS5  = 10;
    localparam int unsigned D5   = 11;
    localparam int unsigned GS4  = 12;

    // Voice state encoding
    typedef logic [1:0] voice_state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Half-period in 50 MHz clock cycles; unpopulated codes return 0 and play as rest
    function automatic int unsigned half_period(input int unsigned code);
        case (code)
            A4:      return 56818;
            B4:      return 50619;
            C4:      return 95556;
            D4:      return 85132;
            E4:      return 75843;
            F4:      return 71586;
            G4:      return 63776;
            BF4:     return 53630;
            C5:      return 47778;
            CS5:     return 45096;
            D5:      return 42566;
            GS4:     return 60197;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/tone_voice.sv
// Single square-wave voice: request handshake, pitch phase counter, tick-based duration.
// Optional staccato tail (silent GAP state) when TONE_STACCATO_EN is defined.
module tone_voice
    import tone_pkg::*;
#(
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned DIV_W  = 17,
    parameter int unsigned DUR_W  = 16
`ifdef TONE_STACCATO_EN
    , parameter int unsigned GAP_TICKS = 20
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              stop,
    input  logic              req_valid,
    input  logic [NOTE_W-1:0] req_note,
    input  logic [DUR_W-1:0]  req_dur,
    output logic              req_ready,
    output logic              busy,
    output logic              wave
);

    voice_state_t      state, state_d;
    logic [DIV_W-1:0]  half, half_d;
    logic [DIV_W-1:0]  phase, phase_d;
    logic [DUR_W-1:0]  dur_cnt, dur_d;
    logic              wave_d;
    voice_state_t      start_state;
    logic              enter_gap;

`ifdef TONE_STACCATO_EN
    // Short notes are silent from the start; longer ones go silent for their last GAP_TICKS ticks
    assign start_state = (req_dur <= DUR_W'(GAP_TICKS)) ? ST_GAP : ST_PLAY;
    assign enter_gap   = (dur_cnt - DUR_W'(1)) == DUR_W'(GAP_TICKS);
`else
    assign start_state = ST_PLAY;
    assign enter_gap   = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE) && !stop;
    assign busy      = (state != ST_IDLE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            half    <= '0;
            phase   <= '0;
            dur_cnt <= '0;
            wave    <= 1'b0;
        end else begin
            state   <= state_d;
            half    <= half_d;
            phase   <= phase_d;
            dur_cnt <= dur_d;
            wave    <= wave_d;
        end
    end

    // Next-state: stop overrides everything, otherwise accept / play / count down
    always_comb begin
        state_d = state;
        half_d  = half;
        phase_d = phase;
        dur_d   = dur_cnt;
        wave_d  = wave;
        if (stop) begin
            state_d = ST_IDLE;
            phase_d = '0;
            wave_d  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && (req_dur != '0)) begin
                        state_d = start_state;
                        half_d  = DIV_W'(half_period(32'(req_note)));
                        dur_d   = req_dur;
                        phase_d = '0;
                        wave_d  = 1'b0;
                    end
                end
                ST_PLAY, ST_GAP: begin
                    if ((state == ST_PLAY) && (half != '0)) begin
                        if (phase == half - DIV_W'(1)) begin
                            phase_d = '0;
                            wave_d  = ~wave;
                        end else begin
                            phase_d = phase + DIV_W'(1);
                        end
                    end
                    if (tick) begin
                        if (dur_cnt == DUR_W'(1)) begin
                            state_d = ST_IDLE;
                            phase_d = '0;
                            wave_d  = 1'b0;
                        end else begin
                            dur_d = dur_cnt - DUR_W'(1);
                            if (enter_gap) begin
                                state_d = ST_GAP;
                                wave_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wave_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tone_voice_bank.sv
// Multi-voice tone generator: shared duration prescaler, NUM_VOICES tone_voice instances,
// stop fan-out and registered OR mix for the speaker pin.
// Optional macro TONE_STACCATO_EN adds GAP_TICKS and a silent tail on every note.
module tone_voice_bank
    import tone_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned NOTE_W     = 4,
    parameter int unsigned DIV_W      = 17,
    parameter int unsigned DUR_W      = 16,
    parameter int unsigned TICK_DIV   = 50000
`ifdef TONE_STACCATO_EN
    , parameter int unsigned GAP_TICKS = 20
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_VOICES-1:0]        req_valid,
    output logic [NUM_VOICES-1:0]        req_ready,
    input  logic [NUM_VOICES*NOTE_W-1:0] req_note,
    input  logic [NUM_VOICES*DUR_W-1:0]  req_dur,
    input  logic                         stop,
    output logic [NUM_VOICES-1:0]        busy,
    output logic [NUM_VOICES-1:0]        wave,
    output logic                         out_mix
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] pre_cnt;
    logic              tick;

    assign tick = (pre_cnt == TICK_W'(TICK_DIV - 1));

    // Free-running duration prescaler; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + TICK_W'(1);
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice #(
            .NOTE_W (NOTE_W),
            .DIV_W  (DIV_W),
            .DUR_W  (DUR_W)
`ifdef TONE_STACCATO_EN
            , .GAP_TICKS (GAP_TICKS)
`endif
        ) u_voice (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .stop      (stop),
            .req_valid (req_valid[v]),
            .req_note  (req_note[v*NOTE_W +: NOTE_W]),
            .req_dur   (req_dur[v*DUR_W +: DUR_W]),
            .req_ready (req_ready[v]),
            .busy      (busy[v]),
            .wave      (wave[v])
        );
    end

    // Speaker output: OR of all voices, one cycle behind wave
    always_ff @(posedge clk) begin
        if (rst) begin
            out_mix <= 1'b0;
        end else begin
            out_mix <= |wave;
        end
    end

endmodule

// File: tb/tb_tone_voice_bank.sv
// Self-checking bench for tone_voice_bank. Builds with or without TONE_STACCATO_EN.
module tb_tone_voice_bank;

    localparam int NV = 2;
    localparam int NW = 4;
    localparam int DW = 17;
    localparam int UW = 16;
    localparam int TD = 1000;
`ifdef TONE_STACCATO_EN
    localparam int GT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NV-1:0]    req_valid = '0;
    logic [NV-1:0]    req_ready;
    logic [NV*NW-1:0] req_note = '0;
    logic [NV*UW-1:0] req_dur = '0;
    logic             stop = 1'b0;
    logic [NV-1:0]    busy;
    logic [NV-1:0]    wave;
    logic             out_mix;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_voice_bank #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .DIV_W      (DW),
        .DUR_W      (UW),
        .TICK_DIV   (TD)
`ifdef TONE_STACCATO_EN
        , .GAP_TICKS (GT)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_note  (req_note),
        .req_dur   (req_dur),
        .stop      (stop),
        .busy      (busy),
        .wave      (wave),
        .out_mix   (out_mix)
    );

    // Cycle index since the last clock edge that sampled rst high
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- reference model: each note is a window of cycles ----------------
    logic [NV-1:0] m_act = '0;
    int            m_start [NV];
    int            m_end   [NV];
    int            m_half  [NV];
    int            m_silent[NV];
    logic [NV-1:0] exp_ready = '1;
    logic [NV-1:0] exp_busy = '0;
    logic [NV-1:0] exp_wave = '0;
    logic          exp_mix = 1'b0;
    logic [NV-1:0] prev_wave = '0;

    function automatic int half_of(input int code);
        case (code)
            1: return 56818;   2: return 50619;   3: return 95556;   4: return 85132;
            5: return 75843;   6: return 71586;   7: return 63776;   8: return 53630;
            9: return 47778;   10: return 45096;  11: return 42566;  12: return 60197;
            default: return 0;
        endcase
    endfunction

    function automatic logic m_busy(input int v, input int c);
        return m_act[v] && (c >= m_start[v]) && (c <= m_end[v]);
    endfunction

    function automatic logic m_wave(input int v, input int c);
        if (!m_busy(v, c) || (c >= m_silent[v]) || (m_half[v] == 0)) return 1'b0;
        return (((c - m_start[v]) / m_half[v]) % 2) == 1;
    endfunction

    always @(negedge clk) begin : model
        int c, n1, f, d;
        if (rst) begin
            m_act = '0; prev_wave = '0; exp_busy = '0; exp_wave = '0; exp_mix = 1'b0; exp_ready = '1;
        end else begin
            c = cyc;
            for (int v = 0; v < NV; v++) begin
                exp_busy[v]  = m_busy(v, c);
                exp_wave[v]  = m_wave(v, c);
                exp_ready[v] = !exp_busy[v] && !stop;
            end
            exp_mix   = |prev_wave;
            prev_wave = exp_wave;
            for (int v = 0; v < NV; v++) begin
                d = int'(req_dur[v*UW +: UW]);
                if (stop) begin
                    if (exp_busy[v] && (m_end[v] > c)) m_end[v] = c;
                end else if (req_valid[v] && !exp_busy[v] && (d != 0)) begin
                    n1 = c + 1;
                    f  = n1 + (TD - 1 - (n1 % TD));   // first tick the note sees
                    m_act[v]   = 1'b1;
                    m_start[v] = n1;
                    m_end[v]   = f + (d - 1) * TD;
                    m_half[v]  = half_of(int'(req_note[v*NW +: NW]));
`ifdef TONE_STACCATO_EN
                    m_silent[v] = (d > GT) ? f + (d - GT - 1) * TD + 1 : n1;
`else
                    m_silent[v] = m_end[v] + 1;
`endif
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic sample_edge();
        @(negedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) drive_edge();
        rst = 1'b0;
        sample_edge();
        checks++; if (wave !== '0) begin errors++; $display("FAIL reset_wave got=%b exp=%b", wave, 2'b00); end
        checks++; if (out_mix !== 1'b0) begin errors++; $display("FAIL reset_mix got=%b exp=0", out_mix); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy got=%b exp=%b", busy, 2'b00); end
        checks++; if (req_ready !== '1) begin errors++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 2'b11); end
    endtask

    task automatic test_short_note();
        int len = 0, hi = 0, bad = 0, bad_cyc = -1;
        drive_edge();
        req_valid = 2'b01; req_note[0 +: NW] = NW'(1); req_dur[0 +: UW] = UW'(3);
        sample_edge();
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL short_hs_ready got=%b exp=1", req_ready[0]); end
        drive_edge();
        req_valid = '0;
        for (int i = 0; i < 3500; i++) begin
            sample_edge();
            if ({req_ready, busy, wave, out_mix} !== {exp_ready, exp_busy, exp_wave, exp_mix}) begin
                bad++; if (bad_cyc < 0) bad_cyc = cyc;
            end
            if (busy[0]) len++;
            if (wave[0]) hi++;
            if (!busy[0] && len > 0) break;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL short_trace bad_cycles=%0d first_cyc=%0d exp=0", bad, bad_cyc); end
        checks++; if (len < 2001 || len > 3000) begin errors++; $display("FAIL short_busy_len got=%0d exp=2001..3000", len); end
        checks++; if (hi !== 0) begin errors++; $display("FAIL short_wave_high got=%0d exp=0", hi); end
    endtask

    task automatic test_two_voices();
        int s = -1, tog = -1, trail = 0, bad = 0, bad_cyc = -1, exp_trail;
        drive_edge();
        req_valid = 2'b11;
        req_note[0 +: NW] = NW'(0); req_dur[0 +: UW] = UW'(5);
        req_note[NW +: NW] = NW'(9); req_dur[UW +: UW] = UW'(52);
        sample_edge();
        checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL dual_hs_ready got=%b exp=%b", req_ready, 2'b11); end
        drive_edge();
        req_valid = '0;
        for (int i = 0; i < 54000; i++) begin
            sample_edge();
            if (i == 0) begin
                checks++; if (busy !== 2'b11) begin errors++; $display("FAIL dual_busy_start got=%b exp=%b", busy, 2'b11); end
            end
            if ({req_ready, busy, wave, out_mix} !== {exp_ready, exp_busy, exp_wave, exp_mix}) begin
                bad++; if (bad_cyc < 0) bad_cyc = cyc;
            end
            if (busy[1]) begin
                if (s < 0) s = cyc;
                if (wave[1]) begin
                    if (tog < 0) tog = cyc - s;
                    trail = 0;
                end else if (tog >= 0) begin
                    trail++;
                end
            end else if (s >= 0) begin
                break;
            end
        end
`ifdef TONE_STACCATO_EN
        exp_trail = GT * TD;
`else
        exp_trail = 0;
`endif
        checks++; if (bad !== 0) begin errors++; $display("FAIL dual_trace bad_cycles=%0d first_cyc=%0d exp=0", bad, bad_cyc); end
        checks++; if (tog !== 47778) begin errors++; $display("FAIL c5_first_toggle got=%0d exp=47778", tog); end
        checks++; if (trail !== exp_trail) begin errors++; $display("FAIL silent_tail got=%0d exp=%0d", trail, exp_trail); end
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL dual_end_busy got=%b exp=%b", busy, 2'b00); end
    endtask

    task automatic test_stop();
        int bad = 0, bad_cyc = -1;
        drive_edge();
        req_valid = 2'b11;
        req_note[0 +: NW] = NW'(1);  req_dur[0 +: UW] = UW'(10);
        req_note[NW +: NW] = NW'(5); req_dur[UW +: UW] = UW'(10);
        drive_edge();
        req_valid = '0;
        for (int i = 0; i < 1500; i++) begin
            sample_edge();
            if ({req_ready, busy, wave, out_mix} !== {exp_ready, exp_busy, exp_wave, exp_mix}) begin
                bad++; if (bad_cyc < 0) bad_cyc = cyc;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stop_pre_trace bad_cycles=%0d first_cyc=%0d exp=0", bad, bad_cyc); end
        checks++; if (busy !== 2'b11) begin errors++; $display("FAIL stop_pre_busy got=%b exp=%b", busy, 2'b11); end
        drive_edge();
        stop = 1'b1; req_valid = 2'b11;
        sample_edge();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stop_ready_low got=%b exp=%b", req_ready, 2'b00); end
        drive_edge();
        sample_edge();
        checks++; if ({busy, wave, req_ready} !== 6'b0) begin errors++; $display("FAIL stop_cleared busy/wave/ready got=%b exp=%b", {busy, wave, req_ready}, 6'b0); end
        drive_edge();
        stop = 1'b0; req_valid = '0;
        sample_edge();
        checks++; if ({req_ready, busy} !== 4'b1100) begin errors++; $display("FAIL stop_release ready/busy got=%b exp=%b", {req_ready, busy}, 4'b1100); end
        drive_edge();
        sample_edge();
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL stop_req_ignored got=%b exp=%b", busy, 2'b00); end
    endtask

    task automatic test_back_to_back();
        int bad = 0, bad_cyc = -1, gaps = 0, gap_bad = 0, cur = 0;
        logic seen = 1'b0;
        drive_edge();
        req_valid = 2'b10; req_note[NW +: NW] = NW'(5); req_dur[UW +: UW] = UW'(0);
        drive_edge();
        req_valid = '0;
        sample_edge();
        checks++; if ({busy[1], req_ready[1]} !== 2'b01) begin errors++; $display("FAIL zero_dur busy/ready got=%b exp=%b", {busy[1], req_ready[1]}, 2'b01); end
        drive_edge();
        req_valid = 2'b01; req_note[0 +: NW] = NW'(2); req_dur[0 +: UW] = UW'(1);
        for (int i = 0; i < 2600; i++) begin
            sample_edge();
            if ({req_ready, busy, wave, out_mix} !== {exp_ready, exp_busy, exp_wave, exp_mix}) begin
                bad++; if (bad_cyc < 0) bad_cyc = cyc;
            end
            if (busy[0]) begin
                if (seen && cur > 0) begin
                    gaps++;
                    if (cur != 1) gap_bad++;
                end
                seen = 1'b1; cur = 0;
            end else if (seen) begin
                cur++;
            end
        end
        drive_edge();
        req_valid = '0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_trace bad_cycles=%0d first_cyc=%0d exp=0", bad, bad_cyc); end
        checks++; if (gaps < 2) begin errors++; $display("FAIL b2b_gap_count got=%0d exp>=2", gaps); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_gap_len wrong_gaps=%0d exp=0", gap_bad); end
    endtask

    task automatic test_random();
        int bad = 0, bad_cyc = -1;
        for (int i = 0; i < 12000; i++) begin
            drive_edge();
            stop = ($urandom_range(0, 199) == 0);
            for (int v = 0; v < NV; v++) begin
                req_valid[v] = ($urandom_range(0, 7) == 0);
                req_note[v*NW +: NW] = NW'($urandom_range(0, 15));
                req_dur[v*UW +: UW]  = UW'($urandom_range(0, 3));
            end
            sample_edge();
            if ({req_ready, busy, wave, out_mix} !== {exp_ready, exp_busy, exp_wave, exp_mix}) begin
                bad++; if (bad_cyc < 0) bad_cyc = cyc;
            end
        end
        drive_edge();
        stop = 1'b0; req_valid = '0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL random_trace bad_cycles=%0d first_cyc=%0d exp=0", bad, bad_cyc); end
    endtask

    initial begin
        test_reset();
        test_short_note();
        test_two_voices();
        test_stop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
